seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 24 ++
 rtl/seq_mul.sv | 80 ++++++++
 rtl/seq_alu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default widths, op-code
// constants and the controller state type.
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 32;
  localparam int ALU_OFF_W_DEF = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ADDI);
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// done_o pulses for one cycle once the full 2*WIDTH-bit product is ready.
module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_step_s;

  // Upper half accumulates the multiplicand when the current multiplier bit
  // (LSB of the lower half) is set; the whole register then shifts right.
  assign sum_s       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_step_s = {sum_s, prod_q[WIDTH-1:1]};

  // Next-state logic for the iteration counter and product register
  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = {CNT_W{1'b0}};
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      prod_d = prod_step_s;
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// complete on the accept edge; MUL runs through the iterative seq_mul.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int OFF_W = ALU_OFF_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [OFF_W-1:0] offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zeroflag,
  output logic             op_err
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zeroflag_q, zeroflag_d;
  logic             op_err_q, op_err_d;

  logic               in_ready_s;
  logic               accept_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   off_ext_s;
  logic [WIDTH-1:0]   fast_res_s;
  logic               fast_err_s;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign in_ready_s  = rst_n && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
  assign accept_s    = in_valid && in_ready_s;
  assign mul_start_s = accept_s && (op == OP_MUL);
  assign off_ext_s   = WIDTH'(offset);

  seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start_s),
    .a_i     (in_1),
    .b_i     (in_2),
    .done_o  (mul_done_s),
    .prod_o  (mul_prod_s)
  );

  // Single-cycle datapath for every op except MUL
  always_comb begin
    fast_res_s = {WIDTH{1'b0}};
    fast_err_s = !op_is_legal(op);
    case (op)
      OP_ADD:  fast_res_s = in_1 + in_2;
      OP_SUB:  fast_res_s = in_2 - in_1;
      OP_NOT:  fast_res_s = ~in_1;
      OP_ADDI: fast_res_s = in_1 + off_ext_s;
      default: fast_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Controller next state and result capture
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zeroflag_d  = zeroflag_q;
    op_err_d    = op_err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d     = ST_DONE;
            result_d    = fast_res_s;
            result_hi_d = {WIDTH{1'b0}};
            zeroflag_d  = (fast_res_s == {WIDTH{1'b0}});
            op_err_d    = fast_err_s;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d     = ST_DONE;
          result_d    = mul_prod_s[WIDTH-1:0];
          result_hi_d = mul_prod_s[2*WIDTH-1:WIDTH];
          zeroflag_d  = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
          op_err_d    = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zeroflag_q  <= 1'b1;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zeroflag_q  <= zeroflag_d;
      op_err_q    <= op_err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zeroflag  = zeroflag_q;
  assign op_err    = op_err_q;

endmodule
